// File: rtl/data_mem_arbiter_pkg.sv
// data_mem_arbiter_pkg: shared types and default constants for the data memory arbiter.
package data_mem_arb_pkg;
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_e;
    typedef logic id_t;
    localparam int unsigned WAIT_CYCLES_DEF = 2;
    localparam int unsigned BASE_ADDR_DEF = 1024;
    localparam int unsigned MEM_DEPTH_DEF = 65536;
endpackage

// File: rtl/data_mem_arbiter_if.sv
// data_mem_arbiter_if: requester ports and memory bus of the data memory arbiter.
interface data_mem_arbiter_if;
    logic req0, req1, we0, we1, ack0, ack1, err0, err1, freeze, mem_read, mem_write;
    logic [31:0] addr0, addr1, wdata0, wdata1, rdata, mem_addr, mem_wdata, mem_rdata;
    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
        output ack0, ack1, err0, err1, rdata, freeze, mem_read, mem_write, mem_addr, mem_wdata
    );
    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
        input  ack0, ack1, err0, err1, rdata, freeze, mem_read, mem_write, mem_addr, mem_wdata
    );
endinterface

// File: rtl/data_mem_arbiter_pick2.sv
// arb_pick2: two-way grant select; round-robin on ties when DMEM_ARB_RR_EN is defined,
// otherwise fixed priority to port 0.
module arb_pick2
    import data_mem_arb_pkg::*;
(
    input  logic req0_i,
    input  logic req1_i,
`ifdef DMEM_ARB_RR_EN
    input  id_t  last_i,
`endif
    output id_t  gnt_o
);
`ifdef DMEM_ARB_RR_EN
    always_comb gnt_o = (req0_i && req1_i) ? ~last_i : (~req0_i & req1_i);
`else
    always_comb gnt_o = ~req0_i & req1_i;
`endif
endmodule

// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: arbitrates the single-port data memory between MEM stage and a secondary
// master as fixed-length transactions. DMEM_ARB_RR_EN enables round-robin arbitration.
module data_mem_arbiter
    import data_mem_arb_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = WAIT_CYCLES_DEF,
    parameter int unsigned BASE_ADDR = BASE_ADDR_DEF,
    parameter int unsigned MEM_DEPTH = MEM_DEPTH_DEF
) (
    input logic clk,
    input logic rst,
    data_mem_arbiter_if.slave bus
);
    localparam int unsigned CW = WAIT_CYCLES > 1 ? $clog2(WAIT_CYCLES) : 1;

    state_e state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    id_t id_q, id_d, gnt;
    logic we_q, we_d, err_q, err_d, any_req, in_win, sel_we;
    logic [29:0] waddr_q, waddr_d;
    logic [31:0] wdata_q, wdata_d, rdata_q, rdata_d, sel_addr, sel_wdata;

    assign any_req = bus.req0 | bus.req1;

`ifdef DMEM_ARB_RR_EN
    id_t last_q, last_d;
    arb_pick2 u_pick (.req0_i(bus.req0), .req1_i(bus.req1), .last_i(last_q), .gnt_o(gnt));
    always_comb last_d = (state_q == IDLE && any_req) ? gnt : last_q;
    always_ff @(posedge clk) last_q <= rst ? id_t'(1'b1) : last_d;
`else
    arb_pick2 u_pick (.req0_i(bus.req0), .req1_i(bus.req1), .gnt_o(gnt));
`endif

    always_comb begin
        sel_addr  = gnt ? bus.addr1 : bus.addr0;
        sel_wdata = gnt ? bus.wdata1 : bus.wdata0;
        sel_we    = gnt ? bus.we1 : bus.we0;
        // 33-bit compare so BASE_ADDR + MEM_DEPTH cannot wrap
        in_win    = ({1'b0, sel_addr} >= 33'(BASE_ADDR)) &&
                    ({1'b0, sel_addr} < 33'(BASE_ADDR) + 33'(MEM_DEPTH));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            id_q    <= '0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            id_q    <= id_d;
            we_q    <= we_d;
            err_q   <= err_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        id_d    = id_q;
        we_d    = we_q;
        err_d   = err_q;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: if (any_req) begin
                id_d    = gnt;
                we_d    = sel_we;
                waddr_d = sel_addr[31:2];
                wdata_d = sel_wdata;
                err_d   = ~in_win;
                cnt_d   = in_win ? CW'(WAIT_CYCLES - 1) : '0;
                state_d = in_win ? ACCESS : DONE;
            end
            ACCESS: begin
                cnt_d   = (cnt_q == '0) ? '0 : cnt_q - CW'(1);
                state_d = (cnt_q == '0) ? DONE : ACCESS;
                rdata_d = (cnt_q == '0 && !we_q) ? bus.mem_rdata : rdata_q;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.ack0      = state_q == DONE && !id_q;
        bus.ack1      = state_q == DONE && id_q;
        bus.err0      = bus.ack0 & err_q;
        bus.err1      = bus.ack1 & err_q;
        bus.freeze    = bus.req0 & ~bus.ack0;
        // a write strobes only once, on the final access cycle
        bus.mem_read  = state_q == ACCESS && !we_q;
        bus.mem_write = state_q == ACCESS && we_q && cnt_q == '0;
        bus.mem_addr  = {waddr_q, 2'b00};
        bus.mem_wdata = wdata_q;
        bus.rdata     = rdata_q;
    end
endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb_data_mem_arbiter: directed stimulus with a scoreboard monitor checking every ack.
module tb_data_mem_arbiter;
    logic clk = 1'b0;
    logic rst;
    data_mem_arbiter_if bus();

    data_mem_arbiter #(.WAIT_CYCLES(2), .BASE_ADDR(1008), .MEM_DEPTH(256)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct {bit p; bit err; logic [31:0] rd;} exp_t;
    exp_t sb[$];
    int tests = 0;
    int fails = 0;

    logic [31:0] mem [64];
    logic [31:0] off;
    assign off = bus.mem_addr - 32'd1008;
    assign bus.mem_rdata = mem[off[7:2]];
    always @(posedge clk) if (bus.mem_write) mem[off[7:2]] <= bus.mem_wdata;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst && (bus.ack0 || bus.ack1)) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL sb.unexpected_ack: got ack0=%0b ack1=%0b expected none", bus.ack0, bus.ack1);
            end else begin
                e = sb.pop_front();
                chk("sb.single", 32'(bus.ack0 & bus.ack1), 0);
                chk("sb.port", 32'(bus.ack1), 32'(e.p));
                chk("sb.err", 32'(bus.ack1 ? bus.err1 : bus.err0), 32'(e.err));
                chk("sb.rdata", bus.rdata, e.rd);
            end
        end
    end

    task automatic txn(input string nm, input bit p, input bit we, input logic [31:0] a,
                       input logic [31:0] wd, input int lat, input int nr, input int nw,
                       input int wc, input logic [31:0] ma, input bit err, input logic [31:0] rd);
        int n = 0, cr = 0, cw = 0, cf = 0, wat = 0;
        bit done = 0, seen = 0;
        logic [31:0] sa = '0;
        sb.push_back('{p, err, rd});
        @(posedge clk);
        #1;
        if (p) begin
            bus.req1 = 1; bus.we1 = we; bus.addr1 = a; bus.wdata1 = wd;
        end else begin
            bus.req0 = 1; bus.we0 = we; bus.addr0 = a; bus.wdata0 = wd;
        end
        while (!done && n < 20) begin
            @(negedge clk);
            n++;
            if (bus.mem_read) cr++;
            if (bus.mem_write) begin cw++; wat = n; end
            if ((bus.mem_read || bus.mem_write) && !seen) begin sa = bus.mem_addr; seen = 1; end
            if (bus.freeze) cf++;
            if (p ? bus.ack1 : bus.ack0) begin
                done = 1; bus.req0 = 0; bus.req1 = 0;
            end
        end
        chk({nm, ".ack_cycle"}, done ? n : -1, lat);
        chk({nm, ".reads"}, cr, nr);
        chk({nm, ".writes"}, cw, nw);
        chk({nm, ".freeze"}, cf, p ? 0 : lat - 1);
        if (nw > 0) chk({nm, ".write_cycle"}, wat, wc);
        if (nr + nw > 0) chk({nm, ".mem_addr"}, sa, ma);
    endtask

    initial begin
        int n, a0, a1, cw, k;
        for (int i = 0; i < 64; i++) mem[i] = '0;
        mem[0] = 32'd5;
        mem[63] = 32'h1234_5678;
        {bus.req0, bus.req1, bus.we0, bus.we1} = '0;
        {bus.addr0, bus.addr1, bus.wdata0, bus.wdata1} = '0;
        rst = 1;
        bus.req0 = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset.strobes", 32'({bus.ack0, bus.ack1, bus.err0, bus.err1, bus.mem_read, bus.mem_write}), 0);
        chk("reset.rdata", bus.rdata, 0);
        chk("reset.mem_addr", bus.mem_addr, 0);
        chk("reset.freeze", 32'(bus.freeze), 1);
        bus.req0 = 0;
        rst = 0;

        txn("rd1008", 0, 0, 1008, 0, 4, 2, 0, 0, 1008, 0, 5);
        txn("wr1016", 1, 1, 1016, 32'hDEADBEEF, 4, 0, 1, 3, 1016, 0, 5);
        txn("rd1016", 0, 0, 1016, 0, 4, 2, 0, 0, 1016, 0, 32'hDEADBEEF);
        txn("rd1011", 0, 0, 1011, 0, 4, 2, 0, 0, 1008, 0, 5);
        txn("below", 0, 0, 1000, 0, 2, 0, 0, 0, 0, 1, 5);
        txn("top_in", 0, 0, 1263, 0, 4, 2, 0, 0, 1260, 0, 32'h1234_5678);
        txn("above", 1, 1, 1264, 32'h0BAD_0BAD, 2, 0, 0, 0, 0, 1, 32'h1234_5678);

        sb.push_back('{0, 0, 32'd5});
        sb.push_back('{1, 0, 32'hDEADBEEF});
        @(posedge clk);
        #1;
        bus.req0 = 1; bus.we0 = 0; bus.addr0 = 1008;
        bus.req1 = 1; bus.we1 = 0; bus.addr1 = 1016;
        n = 0; a0 = -1; a1 = -1;
        while ((a0 < 0 || a1 < 0) && n < 30) begin
            @(negedge clk);
            n++;
            if (bus.ack0) begin a0 = n; bus.req0 = 0; end
            if (bus.ack1) begin a1 = n; bus.req1 = 0; end
        end
        chk("cont.ack0_cycle", a0, 4);
        chk("cont.ack1_cycle", a1, 8);

`ifdef DMEM_ARB_RR_EN
        for (int i = 0; i < 2; i++) begin
            sb.push_back('{0, 0, 32'd5});
            sb.push_back('{1, 0, 32'hDEADBEEF});
        end
        @(posedge clk);
        #1;
        bus.req0 = 1; bus.req1 = 1;
        n = 0; k = 0;
        while (k < 4 && n < 40) begin
            @(negedge clk);
            n++;
            if (bus.ack0 || bus.ack1) begin
                chk("rr.order", 32'(bus.ack1), 32'(k % 2));
                chk("rr.cycle", n, 4 * (k + 1));
                k++;
                if (k == 4) begin bus.req0 = 0; bus.req1 = 0; end
            end
        end
        chk("rr.grants", k, 4);
`endif

        @(posedge clk);
        #1;
        bus.req1 = 1; bus.we1 = 1; bus.addr1 = 1020; bus.wdata1 = 32'hCAFE_F00D;
        cw = 0;
        @(negedge clk);
        cw += int'(bus.mem_write);
        @(negedge clk);
        cw += int'(bus.mem_write);
        rst = 1;
        @(negedge clk);
        cw += int'(bus.mem_write);
        chk("rst_mid.strobes", 32'({bus.ack0, bus.ack1, bus.err0, bus.err1, bus.mem_read, bus.mem_write}), 0);
        chk("rst_mid.rdata", bus.rdata, 0);
        chk("rst_mid.mem_addr", bus.mem_addr, 0);
        chk("rst_mid.mem_wdata", bus.mem_wdata, 0);
        rst = 0;
        bus.req1 = 0;
        @(negedge clk);
        cw += int'(bus.mem_write);
        chk("rst_mid.no_write", cw, 0);
        chk("rst_mid.mem", mem[3], 0);

        txn("after_rst", 0, 0, 1008, 0, 4, 2, 0, 0, 1008, 0, 5);
        repeat (3) @(negedge clk);
        chk("sb.drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end
endmodule
